// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight destinations after ID and derives
// stall, bubble, flush, EX forward selects and ID write-back bypass. Counters: HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
   parameter int REG_AW        = 5,
   parameter int STAGES        = 3,
   parameter int RESOLVE_STAGE = 1,
   parameter int CNT_W         = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       id_valid,
   input  logic [REG_AW-1:0]          id_rs1,
   input  logic [REG_AW-1:0]          id_rs2,
   input  logic                       id_use_rs1,
   input  logic                       id_use_rs2,
   input  logic [REG_AW-1:0]          id_rd,
   input  logic                       id_regwrite,
   input  logic                       id_memread,
   input  logic                       ex_hold,
   input  logic                       branch_taken,
   output logic                       stall,
   output logic                       bubble,
   output logic                       flush,
   output logic [$clog2(STAGES)-1:0]  fwd_a,
   output logic [$clog2(STAGES)-1:0]  fwd_b,
   output logic                       id_byp_a,
   output logic                       id_byp_b,
   output logic [CNT_W-1:0]           stall_cnt,
   output logic [CNT_W-1:0]           flush_cnt
);

   localparam int FW = $clog2(STAGES);

   logic [STAGES-1:0] r_v;
   logic [STAGES-1:0] r_rw;
   logic [REG_AW-1:0] r_rd [STAGES];
   // Only the EX slot's load flag ever matters for load-use, so it is the only one kept.
   logic              r_mr0;
   logic [FW-1:0]     r_fwd_a;
   logic [FW-1:0]     r_fwd_b;

   logic [STAGES-1:0] w_prod;
   logic [STAGES-1:0] w_m1;
   logic [STAGES-1:0] w_m2;
   logic              w_load_use;
   logic              w_flush;
   logic              w_bubble;
   logic [FW-1:0]     w_sel_a;
   logic [FW-1:0]     w_sel_b;

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         w_prod[k] = r_v[k] & r_rw[k] & (r_rd[k] != '0);
         w_m1[k]   = id_use_rs1 & w_prod[k] & (r_rd[k] == id_rs1);
         w_m2[k]   = id_use_rs2 & w_prod[k] & (r_rd[k] == id_rs2);
      end
   end

   assign w_load_use = id_valid & w_prod[0] & r_mr0 & (w_m1[0] | w_m2[0]);
   assign w_flush    = branch_taken & ~ex_hold;
   assign w_bubble   = w_load_use & ~ex_hold & ~w_flush;

   assign flush  = w_flush;
   assign bubble = w_bubble;
   assign stall  = ex_hold | (w_load_use & ~w_flush);

   // Youngest in-flight producer wins; the WB entry is served by the ID bypass instead.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int j = STAGES - 2; j >= 0; j--) begin
         if (w_m1[j]) w_sel_a = FW'(j + 1);
         if (w_m2[j]) w_sel_b = FW'(j + 1);
      end
   end

   assign id_byp_a = w_m1[STAGES-1] & ~(|w_m1[STAGES-2:0]);
   assign id_byp_b = w_m2[STAGES-1] & ~(|w_m2[STAGES-2:0]);

   assign fwd_a = r_fwd_a;
   assign fwd_b = r_fwd_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v     <= '0;
         r_rw    <= '0;
         r_mr0   <= 1'b0;
         r_fwd_a <= '0;
         r_fwd_b <= '0;
         for (int i = 0; i < STAGES; i++) r_rd[i] <= '0;
      end else if (!ex_hold) begin
         r_v[0]  <= id_valid & ~w_bubble & ~w_flush;
         r_rd[0] <= id_rd;
         r_rw[0] <= id_regwrite;
         r_mr0   <= id_memread;
         for (int i = 1; i < STAGES; i++) begin
            r_v[i]  <= r_v[i-1] & ~(w_flush & (i <= RESOLVE_STAGE));
            r_rd[i] <= r_rd[i-1];
            r_rw[i] <= r_rw[i-1];
         end
         if (w_bubble || w_flush || !id_valid) begin
            r_fwd_a <= '0;
            r_fwd_b <= '0;
         end else begin
            r_fwd_a <= w_sel_a;
            r_fwd_b <= w_sel_b;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (!ex_hold) begin
         if (w_bubble && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// compared against a queue-of-instructions reference model.
module tb_hazard_scoreboard;

   localparam int STAGES = 3;
   localparam int RES    = 1;
   localparam int AW     = 5;
   localparam int FW     = $clog2(STAGES);

   logic          clk = 1'b0;
   logic          reset;
   logic          id_valid;
   logic [AW-1:0] id_rs1, id_rs2, id_rd;
   logic          id_use_rs1, id_use_rs2, id_regwrite, id_memread;
   logic          ex_hold, branch_taken;
   logic          stall, bubble, flush, id_byp_a, id_byp_b;
   logic [FW-1:0] fwd_a, fwd_b;
   logic [31:0]   stall_cnt, flush_cnt;

   hazard_scoreboard #(.REG_AW(AW), .STAGES(STAGES), .RESOLVE_STAGE(RES), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_hold(ex_hold),
      .branch_taken(branch_taken), .stall(stall), .bubble(bubble), .flush(flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: in-flight instructions, index 0 = EX, oldest at the back.
   typedef struct {
      bit v;
      int rd;
      bit rw;
      bit mr;
   } ent_t;

   ent_t   pipe[$];
   int     m_fwd_a, m_fwd_b;
   longint m_scnt, m_fcnt;
   int     n_checks = 0;
   int     n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      ent_t e;
      e.v = 0; e.rd = 0; e.rw = 0; e.mr = 0;
      pipe.delete();
      for (int i = 0; i < STAGES; i++) pipe.push_back(e);
      m_fwd_a = 0; m_fwd_b = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   // Position of the youngest in-flight writer of r, or -1.
   function automatic int youngest(input int r, input bit used);
      if (!used || r == 0) return -1;
      for (int k = 0; k < STAGES; k++)
         if (pipe[k].v && pipe[k].rw && pipe[k].rd == r) return k;
      return -1;
   endfunction

   function automatic bit load_use();
      int k1 = youngest(int'(id_rs1), id_use_rs1);
      int k2 = youngest(int'(id_rs2), id_use_rs2);
      return id_valid && pipe[0].mr && (k1 == 0 || k2 == 0);
   endfunction

   task automatic compare_all();
      int k1 = youngest(int'(id_rs1), id_use_rs1);
      int k2 = youngest(int'(id_rs2), id_use_rs2);
      bit lu = load_use();
      bit fl = branch_taken && !ex_hold;
      check("flush",  flush,  fl);
      check("stall",  stall,  ex_hold || (lu && !fl));
      check("bubble", bubble, lu && !ex_hold && !fl);
      check("byp_a",  id_byp_a, k1 == STAGES - 1);
      check("byp_b",  id_byp_b, k2 == STAGES - 1);
      check("fwd_a",  fwd_a, m_fwd_a);
      check("fwd_b",  fwd_b, m_fwd_b);
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cnt", stall_cnt, m_scnt);
      check("flush_cnt", flush_cnt, m_fcnt);
`else
      check("stall_cnt", stall_cnt, 0);
      check("flush_cnt", flush_cnt, 0);
`endif
   endtask

   task automatic model_clock();
      int   k1, k2;
      bit   fl, bub;
      ent_t e;
      if (ex_hold) return;
      k1  = youngest(int'(id_rs1), id_use_rs1);
      k2  = youngest(int'(id_rs2), id_use_rs2);
      fl  = branch_taken;
      bub = load_use() && !fl;
      if (bub || fl || !id_valid) begin
         m_fwd_a = 0;
         m_fwd_b = 0;
      end else begin
         m_fwd_a = (k1 >= 0 && k1 <= STAGES - 2) ? k1 + 1 : 0;
         m_fwd_b = (k2 >= 0 && k2 <= STAGES - 2) ? k2 + 1 : 0;
      end
      if (bub && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (fl && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
      e.v = id_valid && !bub && !fl; e.rd = int'(id_rd); e.rw = id_regwrite; e.mr = id_memread;
      pipe.push_front(e);
      void'(pipe.pop_back());
      if (fl) for (int i = 1; i <= RES; i++) pipe[i].v = 0;
   endtask

   task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit rw, input bit mr, input bit hold, input bit br);
      @(negedge clk);
      id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = AW'(rd); id_regwrite = rw; id_memread = mr; ex_hold = hold; branch_taken = br;
   endtask

   task automatic tick();
      #1 compare_all();
      @(posedge clk);
      model_clock();
   endtask

   task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit hold, input bit br);
      drive(v, rs1, rs2, u1, u2, rd, rw, mr, hold, br);
      tick();
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1 model_reset();
      compare_all();
      check("rst_fwd_a", fwd_a, 0);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_rd = 0; id_regwrite = 0; id_memread = 0; ex_hold = 0; branch_taken = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1 compare_all();
      reset = 1'b0;

      // add x5,x1,x2 ; sub x6,x5,x3
      step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
      drive(1, 5, 3, 1, 1, 6, 1, 0, 0, 0);
      #1 check("ex_fwd_stall", stall, 0);
      tick();
      #1 check("ex_fwd_a", fwd_a, 1);
      check("ex_fwd_b", fwd_b, 0);

      // producer x7, independent, consumer on rs2; then the same with rd=x0
      step(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
      step(1, 11, 12, 1, 1, 13, 1, 0, 0, 0);
      step(1, 14, 7, 1, 1, 15, 1, 0, 0, 0);
      #1 check("mem_fwd_b", fwd_b, 2);
      step(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
      step(1, 11, 12, 1, 1, 13, 1, 0, 0, 0);
      step(1, 14, 0, 1, 1, 15, 1, 0, 0, 0);
      #1 check("x0_fwd_b", fwd_b, 0);

      // ld x4 ; add x8,x4,x4 -> one stall cycle, then forward from MEM
      step(1, 1, 0, 1, 0, 4, 1, 1, 0, 0);
      drive(1, 4, 4, 1, 1, 8, 1, 0, 0, 0);
      #1 check("lu_stall", stall, 1);
      check("lu_bubble", bubble, 1);
      tick();
      drive(1, 4, 4, 1, 1, 8, 1, 0, 0, 0);
      #1 check("lu_stall_once", stall, 0);
      tick();
      #1 check("lu_fwd_a", fwd_a, 2);
      check("lu_fwd_b", fwd_b, 2);
`ifdef HAZARD_PERF_CNT_EN
      check("lu_stall_cnt", stall_cnt, 1);
`endif

      // WB bypass, then shadowed by a younger writer
      step(1, 1, 2, 1, 1, 9, 1, 0, 0, 0);
      step(1, 11, 12, 1, 1, 13, 1, 0, 0, 0);
      step(1, 11, 12, 1, 1, 14, 1, 0, 0, 0);
      drive(1, 9, 12, 1, 1, 16, 1, 0, 0, 0);
      #1 check("wb_byp_a", id_byp_a, 1);
      tick();
      step(1, 1, 2, 1, 1, 9, 1, 0, 0, 0);
      step(1, 11, 12, 1, 1, 13, 1, 0, 0, 0);
      step(1, 1, 2, 1, 1, 9, 1, 0, 0, 0);
      drive(1, 9, 12, 1, 1, 16, 1, 0, 0, 0);
      #1 check("young_byp_a", id_byp_a, 0);
      tick();
      #1 check("young_fwd_a", fwd_a, 1);

      // flush beats load-use
      step(1, 1, 0, 1, 0, 4, 1, 1, 0, 0);
      drive(1, 4, 4, 1, 1, 8, 1, 0, 0, 1);
      #1 check("br_flush", flush, 1);
      check("br_stall", stall, 0);
      check("br_bubble", bubble, 0);
      tick();
      #1 check("br_fwd_a", fwd_a, 0);
      check("br_fwd_b", fwd_b, 0);

      // hold with branch pending, then async reset mid-stream
      step(1, 1, 2, 1, 1, 20, 1, 0, 0, 0);
      step(1, 20, 2, 1, 1, 21, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 21, 20, 1, 1, 22, 1, 0, 1, 1);
         #1 check("hold_flush", flush, 0);
         check("hold_stall", stall, 1);
         check("hold_fwd_a", fwd_a, 1);
         tick();
      end
      step(1, 21, 20, 1, 1, 22, 1, 0, 0, 0);
      pulse_reset();
      step(1, 21, 20, 1, 1, 22, 1, 0, 0, 0);

      // random traffic over a small register set to provoke hazards
      for (int n = 0; n < 2000; n++) begin
         step($urandom_range(0, 5) != 0, $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 249) == 0) pulse_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
